// File: rtl/bomb_controller.sv
// Bomb placement and fuse controller: snaps the bomb to the tile grid under the
// player, runs the fuse, pulses the detonation strobe and flags bomb/blast pixels.
module bomb_controller #(
    parameter int FUSE_TICKS  = 200_000_000,
    parameter int BLAST_TICKS = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       C,
    input  logic       game_over,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    input  logic [9:0] v_x,
    input  logic [9:0] v_y,
    output logic [9:0] e_x,
    output logic [9:0] e_y,
    output logic       explosion_SCEN,
    output logic       bomb_active,
    output logic       bomb_on,
    output logic       explosion_on
);

    localparam logic [9:0]  MIN_X      = 10'd143;
    localparam logic [9:0]  MIN_Y      = 10'd34;
    localparam logic [27:0] FUSE_LAST  = 28'(FUSE_TICKS - 1);
    localparam logic [27:0] BLAST_LAST = 28'(BLAST_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FUSE,
        BLAST
    } state_t;

    state_t      state_q, state_d;
    logic [27:0] cnt_q, cnt_d;
    logic [9:0]  ex_q, ex_d;
    logic [9:0]  ey_q, ey_d;
    logic        cPrev_q;
    logic        scen_q, scen_d;
    logic        active_q, active_d;

    logic        place;
    logic [9:0]  offX, offY;
    logic [9:0]  snapX, snapY;

    assign place = C & ~cPrev_q;

    // Modular 10-bit arithmetic gives the same low ten bits as the 11-bit form.
    assign offX  = b_x + 10'd8 - MIN_X;
    assign offY  = b_y + 10'd8 - MIN_Y;
    assign snapX = MIN_X + {offX[9:4], 4'b0000};
    assign snapY = MIN_Y + {offY[9:4], 4'b0000};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ex_q     <= MIN_X;
            ey_q     <= MIN_Y;
            cPrev_q  <= 1'b0;
            scen_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ex_q     <= ex_d;
            ey_q     <= ey_d;
            cPrev_q  <= C;
            scen_q   <= scen_d;
            active_q <= active_d;
        end
    end

    // One counter serves both timed phases; the strobe is registered on the FUSE->BLAST hop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ex_d    = ex_q;
        ey_d    = ey_q;
        scen_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (place && !game_over) begin
                    state_d = FUSE;
                    cnt_d   = '0;
                    ex_d    = snapX;
                    ey_d    = snapY;
                end
            end
            FUSE: begin
                if (cnt_q == FUSE_LAST) begin
                    state_d = BLAST;
                    cnt_d   = '0;
                    scen_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 28'd1;
                end
            end
            BLAST: begin
                if (cnt_q == BLAST_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 28'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        active_d = (state_d != IDLE);
    end

    logic [10:0] vx11, vy11, ex11, ey11;
    logic        inColX, inRowY, beamH, beamV;

    assign vx11 = {1'b0, v_x};
    assign vy11 = {1'b0, v_y};
    assign ex11 = {1'b0, ex_q};
    assign ey11 = {1'b0, ey_q};

    // Beam reach terms sit on the pixel side so a bomb near the top edge cannot wrap.
    assign inColX = (vx11 >= ex11) && (vx11 <= ex11 + 11'd15);
    assign inRowY = (vy11 >= ey11) && (vy11 <= ey11 + 11'd15);
    assign beamH  = inRowY && (vx11 + 11'd48 >= ex11) && (vx11 <= ex11 + 11'd63);
    assign beamV  = inColX && (vy11 + 11'd48 >= ey11) && (vy11 <= ey11 + 11'd63);

    assign bomb_on        = (state_q == FUSE) && inColX && inRowY;
    assign explosion_on   = (state_q == BLAST) && (beamH || beamV);
    assign e_x            = ex_q;
    assign e_y            = ey_q;
    assign explosion_SCEN = scen_q;
    assign bomb_active    = active_q;

endmodule

// File: tb/tb_bomb_controller.sv
// Self-checking bench for bomb_controller: constant tables, hand sequences for the
// timing corners, and random stimulus against a bomb-age reference model.
module tb_bomb_controller;

    localparam int F = 10;
    localparam int B = 5;

    logic       clk = 1'b0;
    logic       reset, C, game_over;
    logic [9:0] b_x, b_y, v_x, v_y;
    logic [9:0] e_x, e_y;
    logic       explosion_SCEN, bomb_active, bomb_on, explosion_on;

    bomb_controller #(.FUSE_TICKS(F), .BLAST_TICKS(B)) dut (
        .clk(clk), .reset(reset), .C(C), .game_over(game_over),
        .b_x(b_x), .b_y(b_y), .v_x(v_x), .v_y(v_y),
        .e_x(e_x), .e_y(e_y), .explosion_SCEN(explosion_SCEN),
        .bomb_active(bomb_active), .bomb_on(bomb_on), .explosion_on(explosion_on)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // Reference model: a bomb is described only by its age in cycles since placement.
    bit mActive, mPrevC, mScen;
    int mAge, mEx, mEy;

    typedef struct { int bx; int by; int ex; int ey; } snapVec_t;
    typedef struct { int vx; int vy; bit on; } pixVec_t;

    snapVec_t snapTab[5];
    pixVec_t  blastTab[6];

    function automatic int snap(input int b, input int mn);
        return mn + ((b + 8 - mn) / 16) * 16;
    endfunction

    function automatic bit inBomb(input int vx, input int vy);
        return vx >= mEx && vx <= mEx + 15 && vy >= mEy && vy <= mEy + 15;
    endfunction

    function automatic bit inPlus(input int vx, input int vy);
        bit h, v;
        h = vy >= mEy && vy <= mEy + 15 && vx >= mEx - 48 && vx <= mEx + 63;
        v = vx >= mEx && vx <= mEx + 15 && vy >= mEy - 48 && vy <= mEy + 63;
        return h || v;
    endfunction

    task automatic modelEdge();
        bit place;
        if (reset) begin
            mActive = 0; mPrevC = 0; mScen = 0; mAge = 0; mEx = 143; mEy = 34;
        end else begin
            place  = C && !mPrevC;
            mPrevC = C;
            mScen  = 0;
            if (!mActive) begin
                if (place && !game_over) begin
                    mActive = 1;
                    mAge    = 0;
                    mEx     = snap(int'(b_x), 143);
                    mEy     = snap(int'(b_y), 34);
                end
            end else begin
                mAge++;
                mScen = (mAge == F);
                if (mAge == F + B) mActive = 0;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkModel();
        bit bon, eon;
        logic [23:0] act, expv;
        bon  = mActive && mAge < F && inBomb(int'(v_x), int'(v_y));
        eon  = mActive && mAge >= F && inPlus(int'(v_x), int'(v_y));
        act  = {e_x, e_y, explosion_SCEN, bomb_active, bomb_on, explosion_on};
        expv = {10'(mEx), 10'(mEy), mScen, mActive, bon, eon};
        checkOutput("model{ex,ey,scen,act,bon,eon}", 32'(act), 32'(expv));
    endtask

    task automatic applyStimulus(input bit r, input bit c, input bit g);
        reset = r; C = c; game_over = g;
        @(posedge clk);
        modelEdge();
        #1;
        checkModel();
        if (explosion_SCEN === 1'b1) pulses++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0);
    endtask

    initial begin
        snapTab[0] = '{200, 100, 207, 98};
        snapTab[1] = '{150, 40, 143, 34};
        snapTab[2] = '{143, 34, 143, 34};
        snapTab[3] = '{768, 500, 767, 498};
        snapTab[4] = '{158, 49, 159, 50};

        blastTab[0] = '{159, 98, 1};
        blastTab[1] = '{207, 50, 1};
        blastTab[2] = '{207, 161, 1};
        blastTab[3] = '{158, 98, 0};
        blastTab[4] = '{207, 162, 0};
        blastTab[5] = '{230, 120, 0};

        reset = 1; C = 0; game_over = 0;
        b_x = 10'd200; b_y = 10'd100; v_x = 10'd0; v_y = 10'd0;

        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("reset e_x", 32'(e_x), 143);
        checkOutput("reset e_y", 32'(e_y), 34);
        checkOutput("reset scen", 32'(explosion_SCEN), 0);
        checkOutput("reset active", 32'(bomb_active), 0);
        checkOutput("reset flags", 32'({bomb_on, explosion_on}), 0);

        // Placement, fuse pixel, detonation timing and blast pixel table.
        pulses = 0;
        applyStimulus(0, 1, 0);
        checkOutput("place e_x", 32'(e_x), 207);
        checkOutput("place e_y", 32'(e_y), 98);
        checkOutput("place active", 32'(bomb_active), 1);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(0, 0, 0);
            if (k == 3) begin
                v_x = 10'd222; v_y = 10'd113; #1;
                checkOutput("bomb_on (222,113)", 32'(bomb_on), 1);
                v_x = 10'd223; #1;
                checkOutput("bomb_on (223,113)", 32'(bomb_on), 0);
            end
            if (k == 9)  checkOutput("scen edge9", 32'(explosion_SCEN), 0);
            if (k == 10) checkOutput("scen edge10", 32'(explosion_SCEN), 1);
            if (k == 11) checkOutput("scen edge11", 32'(explosion_SCEN), 0);
            if (k == 12) begin
                for (int i = 0; i < 6; i++) begin
                    v_x = 10'(blastTab[i].vx); v_y = 10'(blastTab[i].vy); #1;
                    checkOutput($sformatf("blast (%0d,%0d)", blastTab[i].vx, blastTab[i].vy),
                                32'(explosion_on), 32'(blastTab[i].on));
                end
            end
            if (k == 14) checkOutput("active edge14", 32'(bomb_active), 1);
            if (k == 15) checkOutput("active edge15", 32'(bomb_active), 0);
        end
        checkOutput("single pulse", 32'(pulses), 1);

        // Snap table, including a bomb on the top row to probe beam wrap.
        for (int i = 0; i < 5; i++) begin
            b_x = 10'(snapTab[i].bx); b_y = 10'(snapTab[i].by);
            applyStimulus(0, 1, 0);
            checkOutput($sformatf("snap e_x b_x=%0d", snapTab[i].bx), 32'(e_x), 32'(snapTab[i].ex));
            checkOutput($sformatf("snap e_y b_y=%0d", snapTab[i].by), 32'(e_y), 32'(snapTab[i].ey));
            for (int k = 1; k <= 16; k++) begin
                applyStimulus(0, 0, 0);
                if (k == 11 && snapTab[i].ey == 34) begin
                    v_x = 10'd143; v_y = 10'd0; #1;
                    checkOutput("top beam (143,0)", 32'(explosion_on), 1);
                    v_y = 10'd97; #1;
                    checkOutput("top beam (143,97)", 32'(explosion_on), 1);
                    v_y = 10'd98; #1;
                    checkOutput("top beam (143,98)", 32'(explosion_on), 0);
                    v_y = 10'd1000; #1;
                    checkOutput("top beam (143,1000)", 32'(explosion_on), 0);
                end
            end
        end

        // Button filtering: long hold, then a re-press during the fuse.
        b_x = 10'd200; b_y = 10'd100;
        pulses = 0;
        for (int k = 0; k < 30; k++) applyStimulus(0, 1, 0);
        checkOutput("hold pulses", 32'(pulses), 1);
        checkOutput("hold no rearm", 32'(bomb_active), 0);
        pulses = 0;
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 0);
        checkOutput("repress place", 32'(bomb_active), 1);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        idleCycles(20);
        checkOutput("repress pulses", 32'(pulses), 1);
        checkOutput("repress idle", 32'(bomb_active), 0);

        // game_over blocks placement but never aborts a running fuse.
        applyStimulus(0, 1, 1);
        checkOutput("game_over blocks", 32'(bomb_active), 0);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 1, 0);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(0, 0, k >= 5);
            if (k == 10) checkOutput("game_over scen edge10", 32'(explosion_SCEN), 1);
        end

        // Reset part-way through the fuse suppresses the pulse.
        pulses = 0;
        applyStimulus(0, 1, 0);
        for (int k = 1; k <= 6; k++) applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("midreset active", 32'(bomb_active), 0);
        idleCycles(16);
        checkOutput("midreset pulses", 32'(pulses), 0);

        // Random stimulus, pixels often steered near the bomb tile.
        for (int i = 0; i < 3000; i++) begin
            bit r, c, g;
            r = ($urandom_range(99, 0) == 0);
            c = ($urandom_range(2, 0) == 0) ? ~C : C;
            g = ($urandom_range(7, 0) == 0);
            b_x = 10'($urandom_range(768, 143));
            b_y = 10'($urandom_range(500, 34));
            if ($urandom_range(1, 0) == 1) begin
                v_x = 10'(mEx + int'($urandom_range(140, 0)) - 60);
                v_y = 10'(mEy + int'($urandom_range(140, 0)) - 60);
            end else begin
                v_x = 10'($urandom_range(1023, 0));
                v_y = 10'($urandom_range(1023, 0));
            end
            applyStimulus(r, c, g);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bomb_controller.md
# bomb_controller

Placement and fuse controller for the player's bomb; the transmitter side of the explosion interface consumed by the bomberman player block. On a press of the centre button it snaps the bomb to the 16×16 tile grid under the player sprite, runs a fuse timer, and then fires a one-cycle `explosion_SCEN` pulse with a stable `e_x`/`e_y`. It holds a blast display window for the plus-shaped explosion, and drives per-pixel `bomb_on`/`explosion_on` flags to the top module.

## Interface
- `FUSE_TICKS`, default 200_000_000: clock cycles from placement to detonation (2 s at 100 MHz).
- `BLAST_TICKS`, default 50_000_000: clock cycles the explosion stays displayed.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `C` in 1: place-bomb button, level input.
- `game_over` in 1: game-over flag from the player block.
- `b_x`, `b_y` in 10 each: player sprite top-left pixel.
- `v_x`, `v_y` in 10 each: current VGA pixel.
- `e_x`, `e_y` out 10 each: bomb/explosion tile top-left pixel. Both are registered.
- `explosion_SCEN` out 1: single-cycle detonation pulse. Registered.
- `bomb_active` out 1: high in FUSE or BLAST. Registered.
- `bomb_on` out 1: current pixel is inside the bomb tile during FUSE. Combinational.
- `explosion_on` out 1: current pixel is inside the explosion plus during BLAST. Combinational.

## Operation
- **Constants:** MIN_X=143, MIN_Y=34, TILE=16. Beam reach is 48 px up/left and 63 px right/down of `e_x`/`e_y`.
- **States:** IDLE, FUSE, BLAST. There is a single counter `cnt`, 28 bits, shared by FUSE and BLAST.
- **Edge detect:** register `c_prev <= C` every cycle. `place = C & ~c_prev`.
- **IDLE → FUSE:** taken when `place & ~game_over`.
  - Load `e_x = MIN_X + (((b_x + 8 - MIN_X) >> 4) << 4)`.
  - Load `e_y = MIN_Y + (((b_y + 8 - MIN_Y) >> 4) << 4)`.
  - Set `cnt = 0`.
  - Do all arithmetic in 11 bits. Valid `b_x` is 143..768 and `b_y` is 34..500, so no underflow occurs.
- **FUSE:** `cnt` increments each cycle.
  - When `cnt == FUSE_TICKS-1`, go to BLAST, set `cnt = 0`, and assert `explosion_SCEN` for exactly that one registered cycle.
  - `place` is ignored in FUSE.
  - `game_over` does not abort the fuse.
- **BLAST:** `cnt` increments. When `cnt == BLAST_TICKS-1`, go to IDLE. `place` is ignored.
- **Position hold:** `e_x`/`e_y` hold from load until the next placement. They are never changed in FUSE or BLAST.
- **`bomb_on`:** `state==FUSE && v_x ∈ [e_x, e_x+15] && v_y ∈ [e_y, e_y+15]`.
- **`explosion_on`:** `state==BLAST` and either beam matches:
  - Horizontal beam: `v_x+48 ≥ e_x && v_x ≤ e_x+63 && v_y ∈ [e_y, e_y+15]`.
  - Vertical beam: `v_x ∈ [e_x, e_x+15] && v_y+48 ≥ e_y && v_y ≤ e_y+63`.
  - All comparisons are 11-bit unsigned, with terms moved so nothing wraps (`e_y` can be below 48).
- **C held:** holding `C` across BLAST→IDLE does not place a new bomb. A new rising edge is required.
- **Reset:** returns to IDLE from any state. No pulse is issued for an aborted fuse.

## Timing
- **Reset values:** state IDLE, `cnt=0`, `c_prev=0`, `e_x=143`, `e_y=34`, `explosion_SCEN=0`, `bomb_active=0`, `bomb_on=0`, `explosion_on=0`.
- **Placement:** `place` sampled high at edge N gives `bomb_active=1` and a valid `e_x`/`e_y` from edge N.
- **Detonation:** `explosion_SCEN` is high for the single cycle following edge N+FUSE_TICKS. `e_x`/`e_y` are stable in that cycle, and BLAST begins in the same cycle.
- **Return to IDLE:** at edge N+FUSE_TICKS+BLAST_TICKS. `bomb_active` falls there.
- **Earliest next placement:** a rising edge of `C` sampled at edge N+FUSE_TICKS+BLAST_TICKS or later.
- **Pixel flags:** zero latency from `v_x`/`v_y`.

## Test plan
Use `FUSE_TICKS=10` and `BLAST_TICKS=5` for all scenarios.
1. **Reset:** assert `reset` for 2 cycles. All outputs take their reset values, including `e_x=143` and `e_y=34`.
2. **Placement and pulse:** set `b_x=200`, `b_y=100`, pulse `C` at edge 0.
   - `e_x=207`, `e_y=98`, and `bomb_active` rises after edge 0.
   - `explosion_SCEN` is high for exactly 1 cycle after edge 10.
   - `bomb_active` falls at edge 15.
   - A second placement with `b_x=150`, `b_y=40` gives `e_x=143`, `e_y=34`.
3. **Button filtering:** hold `C` high for 30 cycles, then re-press it during FUSE. Exactly one pulse occurs, and there is no second bomb until `C` falls and rises again after IDLE.
4. **game_over:**
   - `game_over=1` in IDLE plus a `C` edge: `bomb_active` stays 0.
   - `game_over` rising at fuse cycle 5: the pulse still fires at edge 10.
5. **Reset mid-fuse:** assert `reset` at fuse cycle 6. The block returns to IDLE and `explosion_SCEN` never asserts.
6. **Pixel flags in BLAST**, with `e=(207,98)`:
   - On: `v=(159,98)`, `(207,50)`, `(207,161)`.
   - Off: `v=(158,98)`, `(207,162)`, `(230,120)`.
   - During FUSE: `bomb_on=1` at `(222,113)` and 0 at `(223,113)`.
   - Also place at `e_y=34` and confirm `(143,0)` is on, with no wrap artifacts at `v_y=1000`.
